rotating_xbar_unroll_buffer: RTL and testbench

- Receive-side counterpart of the rotating crossbar. It accepts a lane-rotated data vector plus the start_select that produced it, and undoes the rotation so lane k returns to its original index.
- Results are held in a 2-entry elastic buffer with valid/ready handshakes on both sides.
- Sits at the collect end of round-robin lane dispatch, e.g. a multi-lane issue/writeback return path.
- Property: crossbar followed by this block, with the same select, is the identity on data.

---
 rtl/rotating_xbar_unroll_buffer.sv | 84 ++++++++
 tb/tb_rotating_xbar_unroll_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rotating_xbar_unroll_buffer.sv
// Undoes the lane rotation applied by the rotating crossbar and holds results in a
// 2-entry elastic buffer with valid/ready on both sides.
module rotating_xbar_unroll_buffer #(
    parameter int NUM_DATA   = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  input_vector_i,
    input  logic [$clog2(NUM_DATA)-1:0]          start_select_i,
    input  logic                                 input_valid_i,
    output logic                                 input_ready_o,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  output_vector_o,
    output logic                                 output_valid_o,
    input  logic                                 output_ready_i,
    output logic [1:0]                           occupancy_o
);

    localparam int SEL_W = $clog2(NUM_DATA);

    // Handshake: a beat moves on either side only in a cycle where valid and ready
    // are both high at the rising edge; valid must hold its data until accepted.

    logic [NUM_DATA-1:0][DATA_WIDTH-1:0] unrolled;
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0] mem_q [2];
    logic [SEL_W-1:0]                    src_idx;

    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    // Output lane k came from rotated lane (k - select), wrapping in SEL_W bits.
    always_comb begin
        unrolled = '0;
        src_idx  = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            src_idx     = SEL_W'(k) - start_select_i;
            unrolled[k] = input_vector_i[src_idx];
        end
    end

    // Ready depends only on the stored count, never on output_ready_i.
    assign input_ready_o   = rst_i | (count_q != 2'd2);
    assign output_valid_o  = ~rst_i & (count_q != 2'd0);
    assign occupancy_o     = rst_i ? 2'd0 : count_q;
    assign output_vector_o = output_valid_o ? mem_q[rd_q] : '0;

    assign push = input_valid_i & input_ready_o;
    assign pop  = output_valid_o & output_ready_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) wr_d = ~wr_q;
        if (pop)  rd_d = ~rd_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is written only on an accepted beat, so idle inputs cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_q] <= unrolled;
        end
    end

endmodule

// File: tb/tb_rotating_xbar_unroll_buffer.sv
// Bench for rotating_xbar_unroll_buffer: directed vector table, backpressure,
// reset and crossbar round-trip sequences checked against a queue model.
module tb_rotating_xbar_unroll_buffer;

    localparam int N = 4;
    localparam int W = 4;
    localparam int S = $clog2(N);

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef logic [S-1:0]        sel_t;

    typedef struct {
        vec_t vec;
        sel_t sel;
        vec_t exp;
    } vec_rec_t;

    logic       clk;
    logic       rst;
    vec_t       input_vector;
    sel_t       start_select;
    logic       input_valid;
    logic       input_ready;
    vec_t       output_vector;
    logic       output_valid;
    logic       output_ready;
    logic [1:0] occupancy;

    int total = 0;
    int bad   = 0;

    logic [N*W-1:0] exp_q[$];

    rotating_xbar_unroll_buffer #(.NUM_DATA(N), .DATA_WIDTH(W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .input_vector_i  (input_vector),
        .start_select_i  (start_select),
        .input_valid_i   (input_valid),
        .input_ready_o   (input_ready),
        .output_vector_o (output_vector),
        .output_valid_o  (output_valid),
        .output_ready_i  (output_ready),
        .occupancy_o     (occupancy)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: input lane j lands on output lane (sel + j) mod N.
    function automatic vec_t derot(input vec_t v, input int s);
        vec_t r;
        r = '0;
        for (int j = 0; j < N; j++) r[(s + j) % N] = v[j];
        return r;
    endfunction

    // Sender-side crossbar: output lane j takes original lane (sel + j) mod N.
    function automatic vec_t xbar(input vec_t v, input int s);
        vec_t r;
        r = '0;
        for (int j = 0; j < N; j++) r[j] = v[(s + j) % N];
        return r;
    endfunction

    // One clock cycle against the queue model; expv is what the beat should read back as.
    task automatic run_cycle(input vec_t vec, input sel_t sel, input logic v,
                             input logic r, input vec_t expv);
        logic do_push, do_pop;
        input_vector = vec;
        start_select = sel;
        input_valid  = v;
        output_ready = r;
        #1;
        check("in_ready", 32'(input_ready), 32'(exp_q.size() != 2));
        check("out_valid", 32'(output_valid), 32'(exp_q.size() != 0));
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
        check("out_vec", 32'(output_vector), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        do_push = v && (exp_q.size() != 2);
        do_pop  = r && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(expv);
    endtask

    task automatic idle(input logic r);
        run_cycle('0, sel_t'($urandom_range(0, N - 1)), 1'b0, r, '0);
    endtask

    // Reset cycle with a beat offered; the beat must be discarded.
    task automatic reset_cycle(input vec_t vec);
        rst          = 1'b1;
        input_vector = vec;
        start_select = '0;
        input_valid  = 1'b1;
        output_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(output_valid), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_in_ready", 32'(input_ready), 32'h1);
        check("rst_out_vec", 32'(output_vector), 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        input_valid = 1'b0;
        exp_q.delete();
    endtask

    vec_rec_t table_v[6];

    initial begin
        rst          = 1'b1;
        input_vector = '0;
        start_select = '0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle(16'h0000);
        reset_cycle(16'h0000);
        idle(1'b0);

        // Directed de-rotation vectors: lane 0 is the low nibble.
        table_v[0] = '{vec: 16'hDCBA, sel: 2'd1, exp: 16'hCBAD};
        table_v[1] = '{vec: 16'h4321, sel: 2'd3, exp: 16'h1432};
        table_v[2] = '{vec: 16'h4321, sel: 2'd0, exp: 16'h4321};
        table_v[3] = '{vec: 16'h4321, sel: 2'd2, exp: 16'h2143};
        table_v[4] = '{vec: 16'hDCBA, sel: 2'd2, exp: 16'hBADC};
        table_v[5] = '{vec: 16'hDCBA, sel: 2'd3, exp: 16'hADCB};
        for (int i = 0; i < 6; i++) begin
            run_cycle(table_v[i].vec, table_v[i].sel, 1'b1, 1'b1, table_v[i].exp);
            idle(1'b1);
            idle(1'b1);
        end

        // Backpressure: fill, offer a third beat, then drain with the sender holding it.
        run_cycle(16'h1234, 2'd0, 1'b1, 1'b0, 16'h1234);
        run_cycle(16'h5678, 2'd0, 1'b1, 1'b0, 16'h5678);
        run_cycle(16'h9ABC, 2'd0, 1'b1, 1'b0, 16'h9ABC);
        check("bp_full_occ", 32'(occupancy), 32'h2);
        check("bp_full_head", 32'(output_vector), 32'h1234);
        run_cycle(16'h9ABC, 2'd0, 1'b1, 1'b1, 16'h9ABC);
        check("bp_ready_after_pop", 32'(input_ready), 32'h1);
        run_cycle(16'h9ABC, 2'd0, 1'b1, 1'b1, 16'h9ABC);
        idle(1'b1);
        idle(1'b1);

        // Steady push and pop at count 1.
        run_cycle(16'h0F0F, 2'd1, 1'b1, 1'b0, derot(16'h0F0F, 1));
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            sel_t s;
            v = vec_t'($urandom());
            s = sel_t'($urandom_range(0, N - 1));
            run_cycle(v, s, 1'b1, 1'b1, derot(v, int'(s)));
            check("pp_occ_one", 32'(occupancy), 32'h1);
        end
        idle(1'b1);
        idle(1'b1);

        // Reset with two beats buffered.
        run_cycle(16'hAAAA, 2'd0, 1'b1, 1'b0, 16'hAAAA);
        run_cycle(16'h5555, 2'd0, 1'b1, 1'b0, 16'h5555);
        reset_cycle(16'hFFFF);
        idle(1'b0);
        run_cycle(16'h4321, 2'd3, 1'b1, 1'b0, 16'h1432);
        check("post_rst_visible", 32'(output_valid), 32'h1);
        idle(1'b1);
        idle(1'b1);

        // Crossbar round trip at full rate: output must equal the original vector.
        for (int i = 0; i < 1000; i++) begin
            vec_t v;
            sel_t s;
            v = vec_t'($urandom());
            s = sel_t'($urandom_range(0, N - 1));
            run_cycle(xbar(v, int'(s)), s, 1'b1, 1'b1, v);
        end
        idle(1'b1);
        idle(1'b1);

        // Random valid/ready mix.
        for (int i = 0; i < 500; i++) begin
            vec_t v;
            sel_t s;
            logic vv, rr;
            v  = vec_t'($urandom());
            s  = sel_t'($urandom_range(0, N - 1));
            vv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            run_cycle(v, s, vv, rr, derot(v, int'(s)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
